// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock with a registered inter-chunk carry
// Ports: clk/rst (async active-high); start/a/b/carryIn/sub sampled when ready=1;
//        ready high in IDLE and DONE; done one-cycle pulse; sum/carryOut/overflow registered at completion.
module seq_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic [IW-1:0]    idx_q;
  logic             c_q, co_q, ov_q, done_q, ready_q;
  logic [CHUNK:0]   chunk_d;
  logic             ov_d, last_d;
  always_comb begin
    chunk_d = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_q};
    acc_d = acc_q;
    acc_d[idx_q*CHUNK +: CHUNK] = chunk_d[CHUNK-1:0];
    ov_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
    last_d = idx_q == IW'(N-1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (state_q == BUSY) begin
        acc_q <= acc_d;
        c_q   <= chunk_d[CHUNK];
        idx_q <= idx_q + 1'b1;
        if (last_d) begin
          sum_q   <= acc_d;
          co_q    <= chunk_d[CHUNK];
          ov_q    <= ov_d;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= DONE;
        end
      end else if (start) begin
        // subtraction folds into addition: a + ~b + !borrow_in
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        c_q     <= carryIn ^ sub;
        idx_q   <= '0;
        ready_q <= 1'b0;
        state_q <= BUSY;
      end else begin
        ready_q <= 1'b1;
        state_q <= IDLE;
      end
    end
  end
  assign ready    = ready_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryOut = co_q;
  assign overflow = ov_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed checks of the chunked adder at 64/16, 32/8 and 16/16
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic        start64 = 0, cin64 = 0, sub64 = 0;
  logic [63:0] a64 = '0, b64 = '0, sum64;
  logic        ready64, done64, co64, ov64;
  logic        start32 = 0;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        ready32, done32, co32, ov32;
  logic        start16 = 0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        ready16, done16, co16, ov16;
  seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) u64 (
    .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64), .carryIn(cin64), .sub(sub64),
    .ready(ready64), .done(done64), .sum(sum64), .carryOut(co64), .overflow(ov64));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .carryIn(1'b0), .sub(1'b0),
    .ready(ready32), .done(done32), .sum(sum32), .carryOut(co32), .overflow(ov32));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .carryIn(1'b0), .sub(1'b0),
    .ready(ready16), .done(done16), .sum(sum16), .carryOut(co16), .overflow(ov16));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    @(negedge clk);
    a64 = a; b64 = b; cin64 = cin; sub64 = sub; start64 = 1;
    @(posedge clk); #1;
    start64 = 0;
  endtask
  // cyc counts edges from the accept edge (inclusive) until done is seen
  task automatic wait64(output int cyc, output int low);
    cyc = 1; low = 0;
    while (!done64 && cyc < 20) begin
      if (!ready64) low++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input logic [63:0] es, input logic eco, input logic eov);
    int cyc, low;
    start_op(a, b, cin, sub);
    wait64(cyc, low);
    check({tag, "_lat"}, 64'(cyc), 64'd5);
    check({tag, "_sum"}, sum64, es);
    check({tag, "_co"}, 64'(co64), 64'(eco));
    check({tag, "_ov"}, 64'(ov64), 64'(eov));
    check({tag, "_rdy"}, 64'(ready64), 64'd1);
  endtask
  initial begin
    int cyc, low;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", sum64, 64'd0);
    check("rst_done", 64'(done64), 64'd0);
    check("rst_ready", 64'(ready64), 64'd1);
    @(negedge clk) rst = 0;
    start_op(64'd56000000000000, 64'd39000000000000, 1'b0, 1'b0);
    wait64(cyc, low);
    check("basic_lat", 64'(cyc), 64'd5);
    check("basic_low", 64'(low), 64'd4);
    check("basic_sum", sum64, 64'd95000000000000);
    check("basic_co", 64'(co64), 64'd0);
    check("basic_ov", 64'(ov64), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done64), 64'd0);
    check("sum_hold", sum64, 64'd95000000000000);
    run64("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    run64("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run64("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run64("sub_bin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
    start_op(64'd100, 64'd23, 1'b0, 1'b0);
    @(negedge clk);
    a64 = 64'd999; b64 = 64'd1; sub64 = 1; start64 = 1;
    @(negedge clk);
    start64 = 0;
    wait64(cyc, low);
    check("busy_ign_done", 64'(done64), 64'd1);
    check("busy_ign_sum", sum64, 64'd123);
    @(posedge clk); #1;
    check("busy_ign_idle", 64'(ready64), 64'd1);
    start_op(64'd1000, 64'd2000, 1'b0, 1'b0);
    wait64(cyc, low);
    check("b2b_first", sum64, 64'd3000);
    a64 = 64'd40; b64 = 64'd10; sub64 = 1; cin64 = 0; start64 = 1;
    @(posedge clk); #1;
    start64 = 0;
    check("b2b_accept", 64'(ready64), 64'd0);
    check("b2b_hold", sum64, 64'd3000);
    wait64(cyc, low);
    check("b2b_lat", 64'(cyc), 64'd5);
    check("b2b_sum", sum64, 64'd30);
    check("b2b_co", 64'(co64), 64'd1);
    start_op(64'd1, 64'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1;
    #1;
    check("mrst_sum", sum64, 64'd0);
    check("mrst_co", 64'(co64), 64'd0);
    check("mrst_done", 64'(done64), 64'd0);
    check("mrst_ready", 64'(ready64), 64'd1);
    @(negedge clk) rst = 0;
    run64("post_rst", 64'd20000, 64'd30000, 1'b0, 1'b0, 64'd50000, 1'b0, 1'b0);
    @(negedge clk);
    a32 = 32'h00FF_FFFF; b32 = 32'd1; start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    cyc = 1;
    while (!done32 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w32_lat", 64'(cyc), 64'd5);
    check("w32_sum", 64'(sum32), 64'h0100_0000);
    check("w32_co", 64'(co32), 64'd0);
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    cyc = 1;
    while (!done16 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_lat", 64'(cyc), 64'd2);
    check("w16_sum", 64'(sum16), 64'd0);
    check("w16_co", 64'(co16), 64'd1);
    check("w16_ov", 64'(ov16), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
